ps2_scan_receiver: RTL
======================

// Module: ps2_scan_receiver
// PURPOSE
//  PS/2 device-to-host receiver; PS2_CLK/PS2_DAT are sampled as data in the system clock domain, never used as a clock.
//  Deframes 11-bit frames, checks odd parity, stop bit and timeout, and folds E0/F0 prefixes into make/break events.
//  Buffers events in a FIFO with a valid/ready output, feeding the keymap/ASCII and LCD logic downstream.
// PARAMETERS
//  FILTER_LEN      8       consecutive equal samples required before a filtered PS2_CLK/PS2_DAT level change (>=2)
//  TIMEOUT_CYCLES  100000  Clock cycles with no strobe in a non-IDLE state before frame abort (2 ms @ 50 MHz)
//  FIFO_DEPTH      8       event FIFO entries; power of 2, >=2
//  CHECK_PARITY    1       1: parity-bad frames discarded; 0: parity ignored, never flagged
// PORTS
//  Clock          in   1   system clock; sole clock of the block
//  Reset_n        in   1   asynchronous, active-low reset
//  PS2_CLK        in   1   raw PS/2 clock line, asynchronous
//  PS2_DAT        in   1   raw PS/2 data line, asynchronous
//  Event_code     out  8   scan code at FIFO head
//  Event_break    out  1   head event was preceded by F0 (key release)
//  Event_extended out  1   head event was preceded by E0
//  Event_valid    out  1   FIFO not empty
//  Event_ready    in   1   consumer accepts head; pop when Event_valid && Event_ready
//  Fifo_count     out  $clog2(FIFO_DEPTH+1)  occupied entries
//  Parity_error   out  1   1-cycle pulse: frame rejected for parity
//  Frame_error    out  1   1-cycle pulse: bad stop bit or timeout abort
//  Overflow       out  1   sticky: an event was dropped on full FIFO; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, prefix flags 0, filters preset to 1 (idle bus).
//  Input path: 2-flop synchroniser per line, then filter of FILTER_LEN cycles.
//  Strobe: one-cycle pulse on each falling edge of filtered PS2_CLK; data is sampled from filtered PS2_DAT.
//  FSM (advances only on strobe, except timeout):
//   IDLE   dat=0 -> DATA, bit_cnt=0; dat=1 -> stay (spurious edge ignored)
//   DATA   shift in LSB first; after bit_cnt==7 -> PARITY
//   PARITY store bit -> STOP
//   STOP   dat=1 and (^{byte,par}==1 or !CHECK_PARITY) -> deliver byte; dat=0 -> Frame_error;
//          parity bad -> Parity_error (parity takes precedence if both fail); always -> IDLE
//  Timeout: counter cleared on every strobe and in IDLE; reaching TIMEOUT_CYCLES-1 outside IDLE -> IDLE,
//   Frame_error pulse, partial byte discarded, prefix flags cleared.
//  Decode of a delivered byte: F0 -> brk=1; E0 -> ext=1; no push for either.
//   Any other byte -> push {ext,brk,byte}, then brk=ext=0. Rejected frame -> brk=ext=0.
//  Latency: push in the cycle after the STOP strobe; Event_valid high one cycle after push when FIFO was empty.
//  FIFO: show-ahead. Event_* are valid whenever Event_valid=1 and are held stable until popped.
//   Full and push -> event dropped, Overflow<=1; a simultaneous pop frees space, so push succeeds.
//   Empty and pop request -> ignored. Push and pop in the same cycle -> count unchanged.
//  Event_ready is don't-care while Event_valid=0. Reset mid-frame -> partial frame lost, no error pulse.
// STRUCTURE
//  ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), PS2_BREAK=8'hF0, PS2_EXT=8'hE0, event struct {ext,brk,code[7:0]}.
//  Sub-module ps2_event_fifo: generic synchronous show-ahead FIFO (WIDTH, DEPTH); count, full, empty outputs.
//  Top: synchroniser + filter, strobe generator, frame FSM + timeout, prefix decoder.
// TESTING
//  Frame 0x1C, good parity, 10 kHz PS/2 clock -> one event code=1C brk=0 ext=0; Event_valid high with ready=0 until ready.
//  Bytes F0,1C -> single event code=1C brk=1; bytes E0,F0,75 -> code=75 ext=1 brk=1; no events for the prefixes.
//  Frame 0x29 with parity flipped -> Parity_error pulse, no event; the next good frame 0x29 is delivered normally.
//  Stop bit 0 -> Frame_error; after 4 data bits the lines idle for >TIMEOUT_CYCLES -> Frame_error, FSM IDLE, next frame OK.
//  Ready=0, FIFO_DEPTH+1 frames sent -> Fifo_count=FIFO_DEPTH, Overflow=1, first DEPTH codes popped in order.
//  A 2-cycle glitch on PS2_CLK (below FILTER_LEN) -> no strobe; Reset_n low mid-frame -> all outputs 0, FIFO empty.

Source files
------------

// File: rtl/ps2_scan_receiver_pkg.sv
// Shared types for the PS/2 scan-code receiver:
// frame FSM states, prefix bytes and the buffered event format.
package ps2_scan_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Event stream from the PS/2 receiver to the keymap/LCD consumer.
// The receiver drives the head event; the consumer drives Event_ready.
interface ps2_scan_receiver_if #(
    parameter int FIFO_DEPTH = 8
) ();

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    Event_code;
    logic          Event_break;
    logic          Event_extended;
    logic          Event_valid;
    logic          Event_ready;
    logic [CW-1:0] Fifo_count;

    modport master (
        output Event_code,
        output Event_break,
        output Event_extended,
        output Event_valid,
        output Fifo_count,
        input  Event_ready
    );

    modport slave (
        input  Event_code,
        input  Event_break,
        input  Event_extended,
        input  Event_valid,
        input  Fifo_count,
        output Event_ready
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// Generic synchronous show-ahead FIFO; head word is visible on Dout
// whenever Empty is low. A push on full is dropped unless a pop frees space.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       Push,
    input  logic [WIDTH-1:0]           Din,
    input  logic                       Pop,
    output logic [WIDTH-1:0]           Dout,
    output logic                       Full,
    output logic                       Empty,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign Full  = (count_q == CW'(DEPTH));
    assign Empty = (count_q == '0);
    assign Count = count_q;
    assign Dout  = mem[rd_ptr_q];

    assign rd_en = Pop && !Empty;
    assign wr_en = Push && (!Full || rd_en);
    assign Drop  = Push && !wr_en;

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= Din;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: oversampled line filtering, frame FSM
// with timeout, E0/F0 prefix folding and a buffered event stream.
module ps2_scan_receiver
    import ps2_scan_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    parameter int CHECK_PARITY   = 1
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 PS2_CLK,
    input  logic                 PS2_DAT,
    ps2_scan_receiver_if.master  evt,
    output logic                 Parity_error,
    output logic                 Frame_error,
    output logic                 Overflow
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int EW = $bits(ps2_event_t);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [1:0]    raw;
    logic [1:0]    flt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          strobe;
    logic          dat;

    assign raw = {dat_sync_q[1], clk_sync_q[1]};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    // A level change is accepted only after FILTER_LEN differing samples.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            flt_q     <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == flt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    flt_q[i]  <= raw[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= flt_q[0];
        end
    end

    assign strobe = clk_prev_q & ~flt_q[0];
    assign dat    = flt_q[1];

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_byte_q;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= shreg_q;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        rx_valid_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        // A stalled frame is abandoned; a strobe always restarts the count.
        if (state_q == IDLE || strobe) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = '0;
            state_d = IDLE;
            ferr_d  = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d   = {dat, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if ((CHECK_PARITY != 0) && !(^{shreg_q, par_q})) begin
                        perr_d = 1'b1;
                    end else if (!dat) begin
                        ferr_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign Parity_error = perr_q;
    assign Frame_error  = ferr_q;

    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       push;
    ps2_event_t push_evt;

    always_comb begin
        brk_d = brk_q;
        ext_d = ext_q;
        push  = 1'b0;
        if (perr_q || ferr_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rx_valid_q) begin
            unique case (1'b1)
                (rx_byte_q == PS2_BREAK): brk_d = 1'b1;
                (rx_byte_q == PS2_EXT):   ext_d = 1'b1;
                default: begin
                    push  = 1'b1;
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            endcase
        end
    end

    assign push_evt = '{ext: ext_q, brk: brk_q, code: rx_byte_q};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
            ext_q <= ext_d;
        end
    end

    ps2_event_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;
    logic       pop;

    assign pop = !fifo_empty && evt.Event_ready;

    ps2_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Push    (push),
        .Din     (push_evt),
        .Pop     (pop),
        .Dout    (head),
        .Full    (fifo_full),
        .Empty   (fifo_empty),
        .Count   (evt.Fifo_count),
        .Drop    (fifo_drop)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Overflow <= 1'b0;
        end else if (fifo_drop) begin
            Overflow <= 1'b1;
        end
    end

    // Head fields are forced to zero while empty so storage needs no reset.
    assign evt.Event_valid    = !fifo_empty;
    assign evt.Event_code     = fifo_empty ? 8'h00 : head.code;
    assign evt.Event_break    = !fifo_empty && head.brk;
    assign evt.Event_extended = !fifo_empty && head.ext;

endmodule
